// File: rtl/dmem_port_arbiter_if.sv
// Shared bundle between the dmem port arbiter, its requester channels and the dmem.
// The arbiter uses the master view; requesters and memory together form the slave view.
interface dmem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        req_wren;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        gnt;
    logic [NUM_CH-1:0]        rvalid;
    logic [DATA_W-1:0]        rdata;
    logic [ADDR_W-1:0]        address_dmem;
    logic [DATA_W-1:0]        data;
    logic                     wren;
    logic [DATA_W-1:0]        q_dmem;

    modport master (
        input  req, req_wren, req_addr, req_data, q_dmem,
        output gnt, rvalid, rdata, address_dmem, data, wren
    );

    modport slave (
        output req, req_wren, req_addr, req_data, q_dmem,
        input  gnt, rvalid, rdata, address_dmem, data, wren
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// N-channel arbiter sharing one single-port synchronous dmem; grants at most one
// access per cycle (round-robin or fixed priority) and returns read data a cycle later.
module dmem_port_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clock,
    input  logic                reset,
    dmem_port_arbiter_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0] r_last_gnt;
    logic [CH_W-1:0] r_rd_id;
    logic            r_rd_pend;

    logic [CH_W-1:0] w_winner;
    logic [CH_W-1:0] w_idx;
    logic            w_found;

    // Round-robin searches starting just after the last winner; fixed priority favours the lowest index.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        if (!reset) begin
            if (FIXED_PRIO != 0) begin
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (bus.req[i]) begin
                        w_winner = CH_W'(i);
                        w_found  = 1'b1;
                    end
                end
            end else begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    w_idx = CH_W'((int'(r_last_gnt) + k) % NUM_CH);
                    if (!w_found && bus.req[w_idx]) begin
                        w_winner = w_idx;
                        w_found  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.gnt          = '0;
        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        if (w_found) begin
            bus.gnt[w_winner] = 1'b1;
            bus.address_dmem  = bus.req_addr[w_winner*ADDR_W +: ADDR_W];
            bus.data          = bus.req_data[w_winner*DATA_W +: DATA_W];
            bus.wren          = bus.req_wren[w_winner];
        end
    end

    // Reset also masks a pending return so a read granted just before reset never reports.
    always_comb begin
        bus.rvalid = '0;
        if (r_rd_pend && !reset) begin
            bus.rvalid[r_rd_id] = 1'b1;
        end
    end

    assign bus.rdata = bus.q_dmem;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_gnt <= CH_W'(NUM_CH - 1);
            r_rd_pend  <= 1'b0;
            r_rd_id    <= '0;
        end else begin
            r_rd_pend <= w_found && !bus.req_wren[w_winner];
            if (w_found) begin
                r_last_gnt <= w_winner;
                r_rd_id    <= w_winner;
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: a 2-channel round-robin arbiter with a dmem model and read scoreboard,
// plus a 4-channel fixed-priority arbiter checked on grant and memory drive.
module tb_dmem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic resetA;
    logic resetB;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    dmem_port_arbiter_if #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW)) busA ();
    dmem_port_arbiter_if #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW)) busB ();

    dmem_port_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dutA (
        .clock (clock),
        .reset (resetA),
        .bus   (busA.master)
    );

    dmem_port_arbiter #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dutB (
        .clock (clock),
        .reset (resetB),
        .bus   (busB.master)
    );

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    wren;
        logic [AW-1:0] addr0;
        logic [AW-1:0] addr1;
        logic [DW-1:0] data0;
        logic [DW-1:0] data1;
        logic [1:0]    gnt;
        logic          expWren;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expData;
    } vec_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] refMem [0:4095];
    logic [DW-1:0] memA   [0:4095];

    // Write-first single-port dmem: q reflects the address presented on the previous edge.
    initial begin
        for (int i = 0; i < 4096; i++) memA[i] = '0;
        memA[1] = 32'h11;
        memA[2] = 32'h22;
        memA[3] = 32'h33;
        busA.q_dmem = '0;
        forever begin
            @(posedge clock);
            if (busA.wren) memA[busA.address_dmem] <= busA.data;
            busA.q_dmem <= busA.wren ? busA.data : memA[busA.address_dmem];
        end
    end

    initial busB.q_dmem = '0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] wren,
                                 input logic [AW-1:0] addr0, input logic [AW-1:0] addr1,
                                 input logic [DW-1:0] data0, input logic [DW-1:0] data1);
        @(posedge clock);
        #1;
        busA.req      = req;
        busA.req_wren = wren;
        busA.req_addr = {addr1, addr0};
        busA.req_data = {data1, data0};
    endtask

    // Every rvalid must match the oldest expected read, in the cycle it is due.
    always @(negedge clock) begin
        exp_t       e;
        logic [1:0] rv;
        if (busA.rvalid != 2'b00) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL rvalid_unexpected: got rvalid=%b, wanted 00", busA.rvalid);
            end else begin
                e  = sbq.pop_front();
                rv = 2'(1 << e.ch);
                if (busA.rvalid !== rv || busA.rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL rvalid_return: got rvalid=%b rdata=%h cyc=%0d, wanted rvalid=%b rdata=%h cyc=%0d",
                             busA.rvalid, busA.rdata, cyc, rv, e.data, e.due);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            checks++;
            errors++;
            e = sbq.pop_front();
            $display("[TB] FAIL rvalid_missing: got rvalid=00 at cyc=%0d, wanted ch%0d data %h", cyc, e.ch, e.data);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t          vecs[12];
        logic [3:0]    bReq[7];
        logic [3:0]    bGnt[7];
        int            idx;
        exp_t          e;

        vecs[0]  = '{2'b11, 2'b10, 12'h001, 12'h020, 32'h0BAD0000, 32'hAAAA0001, 2'b01, 1'b0, 12'h001, 32'h0BAD0000};
        vecs[1]  = '{2'b11, 2'b10, 12'h001, 12'h020, 32'h0BAD0000, 32'hAAAA0001, 2'b10, 1'b1, 12'h020, 32'hAAAA0001};
        vecs[2]  = '{2'b11, 2'b00, 12'h002, 12'h020, 32'h0, 32'h0, 2'b01, 1'b0, 12'h002, 32'h0};
        vecs[3]  = '{2'b11, 2'b00, 12'h002, 12'h020, 32'h0, 32'h0, 2'b10, 1'b0, 12'h020, 32'h0};
        vecs[4]  = '{2'b01, 2'b01, 12'h010, 12'h000, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1, 12'h010, 32'hDEADBEEF};
        vecs[5]  = '{2'b10, 2'b00, 12'h000, 12'h010, 32'h0, 32'h0, 2'b10, 1'b0, 12'h010, 32'h0};
        vecs[6]  = '{2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 2'b00, 1'b0, 12'h000, 32'h0};
        vecs[7]  = '{2'b00, 2'b11, 12'h3FF, 12'h3FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 12'h000, 32'h0};
        vecs[8]  = '{2'b11, 2'b00, 12'h001, 12'h002, 32'h0, 32'h0, 2'b01, 1'b0, 12'h001, 32'h0};
        vecs[9]  = '{2'b10, 2'b00, 12'h000, 12'h003, 32'h0, 32'h0, 2'b10, 1'b0, 12'h003, 32'h0};
        vecs[10] = '{2'b01, 2'b00, 12'h003, 12'h000, 32'h0, 32'h0, 2'b01, 1'b0, 12'h003, 32'h0};
        vecs[11] = '{2'b11, 2'b00, 12'h001, 12'h001, 32'h0, 32'h0, 2'b10, 1'b0, 12'h001, 32'h0};

        bReq = '{4'b1110, 4'b1110, 4'b1110, 4'b1100, 4'b1111, 4'b1000, 4'b0000};
        bGnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0000};

        for (int i = 0; i < 4096; i++) refMem[i] = '0;
        refMem[1] = 32'h11;
        refMem[2] = 32'h22;
        refMem[3] = 32'h33;

        resetA = 1'b1;
        resetB = 1'b1;
        busA.req      = 2'b11;
        busA.req_wren = 2'b10;
        busA.req_addr = {12'h020, 12'h001};
        busA.req_data = {32'hAAAA0001, 32'h0BAD0000};
        busB.req      = 4'b0000;
        busB.req_wren = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            busB.req_addr[i*AW +: AW] = 12'(256 * i + i);
            busB.req_data[i*DW +: DW] = 32'hC0DE0000 + 32'(i);
        end

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_gnt",    64'(busA.gnt), 64'(2'b00));
        checkOutput("reset_wren",   64'(busA.wren), 64'(1'b0));
        checkOutput("reset_addr",   64'(busA.address_dmem), 64'(12'h000));
        checkOutput("reset_data",   64'(busA.data), 64'(32'h0));
        checkOutput("reset_rvalid", 64'(busA.rvalid), 64'(2'b00));

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].req, vecs[i].wren, vecs[i].addr0, vecs[i].addr1, vecs[i].data0, vecs[i].data1);
            if (i == 0) begin
                resetA = 1'b0;
                resetB = 1'b0;
            end
            @(negedge clock);
            checkOutput($sformatf("v%0d_gnt", i),  64'(busA.gnt), 64'(vecs[i].gnt));
            checkOutput($sformatf("v%0d_wren", i), 64'(busA.wren), 64'(vecs[i].expWren));
            checkOutput($sformatf("v%0d_addr", i), 64'(busA.address_dmem), 64'(vecs[i].expAddr));
            checkOutput($sformatf("v%0d_data", i), 64'(busA.data), 64'(vecs[i].expData));
            if (vecs[i].gnt != 2'b00) begin
                if (vecs[i].expWren) begin
                    refMem[vecs[i].expAddr] = vecs[i].expData;
                end else begin
                    e.ch   = (vecs[i].gnt == 2'b10) ? 1 : 0;
                    e.data = refMem[vecs[i].expAddr];
                    e.due  = cyc + 1;
                    sbq.push_back(e);
                end
            end
        end

        applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 32'h0, 32'h0);
        applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 32'h0, 32'h0);

        // A read granted right before reset must never come back.
        applyStimulus(2'b10, 2'b00, 12'h000, 12'h002, 32'h0, 32'h0);
        @(negedge clock);
        checkOutput("rst_pre_gnt", 64'(busA.gnt), 64'(2'b10));
        @(posedge clock);
        #1;
        resetA   = 1'b1;
        busA.req = 2'b11;
        @(negedge clock);
        checkOutput("rst_mid_rvalid", 64'(busA.rvalid), 64'(2'b00));
        checkOutput("rst_mid_gnt",    64'(busA.gnt), 64'(2'b00));
        checkOutput("rst_mid_wren",   64'(busA.wren), 64'(1'b0));
        checkOutput("rst_mid_addr",   64'(busA.address_dmem), 64'(12'h000));
        @(negedge clock);
        checkOutput("rst_hold_rvalid", 64'(busA.rvalid), 64'(2'b00));

        applyStimulus(2'b11, 2'b00, 12'h001, 12'h002, 32'h0, 32'h0);
        resetA = 1'b0;
        @(negedge clock);
        checkOutput("rst_post_gnt", 64'(busA.gnt), 64'(2'b01));
        e.ch   = 0;
        e.data = refMem[1];
        e.due  = cyc + 1;
        sbq.push_back(e);
        applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 32'h0, 32'h0);

        for (int k = 0; k < 7; k++) begin
            @(posedge clock);
            #1;
            busB.req = bReq[k];
            @(negedge clock);
            idx = -1;
            for (int j = 0; j < 4; j++) if (bGnt[k][j]) idx = j;
            checkOutput($sformatf("fp%0d_gnt", k),  64'(busB.gnt), 64'(bGnt[k]));
            checkOutput($sformatf("fp%0d_addr", k), 64'(busB.address_dmem),
                        (idx < 0) ? 64'(0) : 64'(256 * idx + idx));
            checkOutput($sformatf("fp%0d_wren", k), 64'(busB.wren), 64'(|(bGnt[k] & 4'b0101)));
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
